sensor_channel_arbiter: RTL
===========================

Name: sensor_channel_arbiter

Overview:
- Shares the single serial transmitter path between N_CH photodiode decoder channels.
- Each channel gets a one-deep capture slot. A decoded word and its timestamp are latched from the channel, and the channel's decoder is cleared with a one-cycle pulse.
- A round-robin scheduler presents one captured frame at a time, tagged with its channel index, over a valid/ready handshake to the transmitter controller.

Parameters:
- N_CH, 4, number of decoder channels (legal range 2..8).
- DATA_W, 17, decoded word width per channel.
- TS_W, 24, timestamp width per channel.
- CH_W, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk_12MHz  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- ch_valid  in  N_CH  per-channel data available from decoder i.
- ch_data  in  N_CH*DATA_W  packed decoded words; channel i at [i*DATA_W +: DATA_W].
- ch_timestamp  in  N_CH*TS_W  packed timestamps; channel i at [i*TS_W +: TS_W].
- ch_clear  out  N_CH  one-cycle decoder reset pulse per channel.
- slot_full  out  N_CH  capture slot i occupied (status).
- out_valid  out  1  frame presented to transmitter.
- out_ready  in  1  transmitter accepts frame.
- out_data  out  DATA_W  presented decoded word.
- out_timestamp  out  TS_W  presented timestamp.
- out_channel  out  CH_W  source channel of presented frame.

Behaviour:
- Reset (rstn low, asynchronous) clears all of the following, and any in-flight frame is discarded:
  - slot_full = 0, ch_clear = 0, out_valid = 0, out_data = 0, out_timestamp = 0, out_channel = 0.
  - rr_ptr = 0, state = IDLE.
- After reset release, the first capture is possible on the first rising edge.

Capture, per channel i, independent:
- Condition at cycle t: ch_valid[i] = 1 and slot_full[i] = 0 and ch_clear[i] = 0.
- At edge t+1: the slot latches ch_data[i] and ch_timestamp[i], slot_full[i] goes to 1, and ch_clear[i] goes to 1 for exactly one cycle.
- ch_valid[i] seen while ch_clear[i] = 1 is ignored, because the decoder is still deasserting.
- ch_valid[i] = 1 while the slot is full is held off: no clear and no overwrite. The decoder keeps its data until the slot drains, so no data loss is possible in the arbiter.

Scheduler FSM, states IDLE and PRESENT:
- IDLE:
  - If any slot_full bit is set, pick g = first full slot searching from rr_ptr upward, wrapping modulo N_CH.
  - At the next edge: out_data, out_timestamp and out_channel take slot g's contents, out_valid = 1, slot_full[g] = 0, rr_ptr = (g+1) mod N_CH, and state goes to PRESENT.
  - If no slot is full, stay in IDLE.
- PRESENT:
  - out_valid = 1 and the out_* signals are held stable.
  - On an edge with out_ready = 1: out_valid = 0 and state goes to IDLE.
  - out_ready while in IDLE is ignored.

Latency and throughput:
- From ch_valid (cycle t) to out_valid: 2 cycles minimum (t+2).
- Maximum throughput is one frame per 2 cycles while the transmitter is always ready.

Simultaneous events and boundaries:
- A slot freed by a grant at edge e can capture new data at edge e+1 at the earliest, because capture tests the slot_full value registered before edge e. No same-edge conflict is possible.
- Captures on several channels in the same cycle are all accepted.
- Fairness: with all slots continuously full, grant order is 0,1,...,N_CH-1,0,... and no channel waits more than N_CH grants.
- rr_ptr wraps from N_CH-1 to 0.
- out_ready held low indefinitely stalls the scheduler only. Captures continue until every slot is full.

Decomposition:
- Shared package contains:
  - DATA_W = 17 and TS_W = 24 constants.
  - Scheduler state encoding (IDLE, PRESENT).
  - Frame field widths, so the transmitter controller and arbiter agree.
- Sub-module: rr_priority_picker, combinational. Inputs: req[N_CH] and ptr[CH_W]. Outputs: any and grant index[CH_W].
- Capture slots and FSM stay in sensor_channel_arbiter.

Test Plan:
- Single channel, transmitter always ready: ch_valid[2] pulse with data 17'h1ABCD, ts 24'h123456.
  - ch_clear[2] is high one cycle at t+1.
  - out_valid at t+2 with out_channel = 2 and the same data and ts.
  - Handshake completes at the next edge.
- All four channels assert ch_valid on the same cycle, out_ready = 1:
  - Four single-cycle ch_clear pulses on the same edge.
  - Frames emitted in order 0,1,2,3, one every 2 cycles.
  - All slot_full bits are 0 afterwards.
- Backpressure: out_ready = 0 for 50 cycles while channels 1 and 3 present data.
  - out_* remain stable and out_valid is held.
  - Channel 1 stays full with ch_valid held, no second clear and no overwrite.
  - On release, frames follow rr order.
- Fairness with rr_ptr = 3 and all slots full: grant order 3,0,1,2.
  - A re-fill of channel 3 after its grant is served only after channels 0,1,2.
- Asynchronous reset asserted mid-PRESENT, asynchronous to clk:
  - out_valid, ch_clear and slot_full go to 0 immediately.
  - After release, the first grant search starts at channel 0.

Source files
------------

// File: rtl/sensor_channel_arbiter_pkg.sv
// Shared constants and types for the photodiode channel arbiter and the
// transmitter controller that consumes its frames.
package sensor_channel_arbiter_pkg;

  localparam int DATA_W  = 17;
  localparam int TS_W    = 24;
  localparam int FRAME_W = DATA_W + TS_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sched_state_t;

  // Modulo-n add used for round-robin pointer arithmetic on non power-of-two channel counts.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/sensor_channel_arbiter_if.sv
// Frame handshake between the arbiter (master) and the serial transmitter controller (slave).
interface sensor_channel_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = sensor_channel_arbiter_pkg::DATA_W,
  parameter int TS_W   = sensor_channel_arbiter_pkg::TS_W
);
  localparam int CH_W = $clog2(N_CH);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_timestamp;
  logic [CH_W-1:0]   out_channel;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_timestamp,
    output out_channel
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_timestamp,
    input  out_channel
  );
endinterface

// File: rtl/sensor_channel_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N_CH.
module rr_priority_picker #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            any,
  output logic [CH_W-1:0] grant
);
  import sensor_channel_arbiter_pkg::*;

  // Scan from farthest to nearest so the nearest set request is the last write.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(ptr), k, N_CH)]) begin
        any   = 1'b1;
        grant = CH_W'(wrap_add(int'(ptr), k, N_CH));
      end
    end
  end

endmodule

// File: rtl/sensor_channel_arbiter.sv
// Captures one frame per decoder channel into a one-deep slot and serves the
// slots round-robin over a valid/ready handshake to the serial transmitter.
module sensor_channel_arbiter #(
  parameter int N_CH   = 4,
  parameter int DATA_W = sensor_channel_arbiter_pkg::DATA_W,
  parameter int TS_W   = sensor_channel_arbiter_pkg::TS_W
) (
  input  logic                   clk_12MHz,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH*TS_W-1:0]   ch_timestamp,
  output logic [N_CH-1:0]        ch_clear,
  output logic [N_CH-1:0]        slot_full,
  sensor_channel_arbiter_if.master tx
);
  import sensor_channel_arbiter_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  sched_state_t      state;
  logic [CH_W-1:0]   rr_ptr;
  logic [N_CH-1:0]   capture;
  logic [N_CH-1:0]   release_mask;
  logic              pick_any;
  logic [CH_W-1:0]   pick_idx;
  logic [DATA_W-1:0] slot_data_p0 [N_CH];
  logic [TS_W-1:0]   slot_ts_p0   [N_CH];

  // A decoder still deasserting after its clear pulse must not be recaptured.
  assign capture = ch_valid & ~slot_full & ~ch_clear;

  rr_priority_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .req   (slot_full),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .grant (pick_idx)
  );

  always_comb begin
    release_mask = '0;
    if (state == IDLE && pick_any) begin
      release_mask[pick_idx] = 1'b1;
    end
  end

  // Stage p0: per-channel capture slots
  always_ff @(posedge clk_12MHz) begin
    for (int i = 0; i < N_CH; i++) begin
      if (capture[i]) begin
        slot_data_p0[i] <= ch_data[i*DATA_W +: DATA_W];
        slot_ts_p0[i]   <= ch_timestamp[i*TS_W +: TS_W];
      end
    end
  end

  // Stage p1: scheduler and presented frame
  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      slot_full        <= '0;
      ch_clear         <= '0;
      rr_ptr           <= '0;
      state            <= IDLE;
      tx.out_valid     <= 1'b0;
      tx.out_data      <= '0;
      tx.out_timestamp <= '0;
      tx.out_channel   <= '0;
    end else begin
      ch_clear  <= capture;
      slot_full <= (slot_full | capture) & ~release_mask;
      case (state)
        IDLE: begin
          if (pick_any) begin
            tx.out_data      <= slot_data_p0[pick_idx];
            tx.out_timestamp <= slot_ts_p0[pick_idx];
            tx.out_channel   <= pick_idx;
            tx.out_valid     <= 1'b1;
            rr_ptr           <= CH_W'(wrap_add(int'(pick_idx), 1, N_CH));
            state            <= PRESENT;
          end
        end
        PRESENT: begin
          if (tx.out_ready) begin
            tx.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
